trace_recorder: RTL and testbench
=================================

TRACE_RECORDER -- requirements
Module: trace_recorder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning pc/inst/write-data width.
REQ-002 SHALL have parameter DEPTH, default 64, meaning trace buffer entries; power of two, at least 2.
REQ-003 SHALL have parameter CYCLE_LIMIT, default 1200, meaning maximum cycles recorded per run.
REQ-004 SHALL have parameter MODE, default 0, meaning 0 = record every cycle, 1 = record only cycles with rf_we=1.
REQ-005 SHALL have parameter FULL_STOP, default 0, meaning 1 = buffer full ends the run, 0 = drop entry and set overflow.
REQ-006 SHALL have ports: clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have ports: reset  input  1  synchronous, active-low reset.
REQ-008 SHALL have ports: start  input  1  begin run (honoured only in IDLE).
REQ-009 SHALL have ports: clear  input  1  flush buffer, clear flags, return to IDLE.
REQ-010 SHALL have ports: pc_in, inst_in  input  DATA_W  committed pc and instruction.
REQ-011 SHALL have ports: inst_valid  input  1  0 = instruction unknown/invalid (end of program).
REQ-012 SHALL have ports: rf_we  input  1, rf_waddr  input  5, rf_wdata  input  DATA_W  register-file write this cycle.
REQ-013 SHALL have ports: rd_en  input  1  pop request.
REQ-014 SHALL have ports: rd_valid  output  1, rd_pc/rd_inst/rd_wdata  output  DATA_W, rd_we  output  1, rd_waddr  output  5, rd_stamp  output  16  popped entry.
REQ-015 SHALL have ports: count  output  log2(DEPTH)+1, full/empty/overflow/done  output  1, state  output  2.

Function
REQ-016 SHALL implement states IDLE(0), RUN(1), STOP(2); IDLE->RUN on start; RUN->STOP on stop condition; STOP->IDLE on clear; clear from any state goes to IDLE.
REQ-017 SHALL, in RUN, increment a 16-bit cycle counter each cycle, saturating at 16'hFFFF; counter reset to 0 on entry to RUN.
REQ-018 SHALL push {pc_in, inst_in, rf_we, rf_waddr, rf_wdata, cycle counter} in RUN when inst_valid=1 and (MODE=0 or rf_we=1).
REQ-019 SHALL enter STOP the cycle after inst_valid=0 in RUN; that cycle is not pushed.
REQ-020 SHALL enter STOP after CYCLE_LIMIT cycles in RUN; exactly CYCLE_LIMIT cycles eligible for recording.
REQ-021 SHALL, on push while full without same-cycle pop: FULL_STOP=1 -> drop entry, enter STOP; FULL_STOP=0 -> drop entry, set sticky overflow, stay in RUN.
REQ-022 SHALL accept pop when rd_en=1 and empty=0 in any state; data and rd_valid=1 registered, appear next cycle; rd_valid=0 otherwise.
REQ-023 SHALL, on simultaneous push and pop while full, accept both; count unchanged; overflow not set.
REQ-024 SHALL, on simultaneous push and pop while empty, accept push only; count becomes 1, rd_valid=0 next cycle.
REQ-025 SHALL wrap read/write pointers modulo DEPTH; full = (count==DEPTH), empty = (count==0), both combinational from count.
REQ-026 SHALL assert done=1 while state=STOP.
REQ-027 SHALL treat start during RUN/STOP as ignored; clear takes priority over start and push in the same cycle.

Reset
REQ-028 SHALL, when reset=0 at a rising edge, set state=IDLE, pointers/count/cycle counter=0, overflow=0, rd_valid=0, all rd_* data=0, regardless of ongoing run.
REQ-029 SHALL leave buffer RAM contents undefined after reset; only pointers cleared.

Structure
REQ-030 SHALL place state encoding (IDLE/RUN/STOP), stamp width 16 and register-address width 5 in shared package trace_pkg.
REQ-031 SHALL instantiate one sub-module trace_fifo (parametrised width/depth, registered read) holding the buffer; control FSM and counter in trace_recorder.

Verification
REQ-032 SHALL cover: MODE=0, start, 10 valid cycles, inst_valid=0 -> count=10, state=STOP, stamps 0..9 in pop order.
REQ-033 SHALL cover: MODE=1, 20 cycles with rf_we on cycles 3,7,12 -> count=3, popped rd_waddr/rd_wdata match, rd_stamp=3,7,12.
REQ-034 SHALL cover: CYCLE_LIMIT=5, DEPTH=8, continuous valid -> exactly 5 entries, done=1 after 5th cycle.
REQ-035 SHALL cover: DEPTH=4, FULL_STOP=0, 6 cycles, no pops -> count=4, overflow=1, state=RUN; FULL_STOP=1 -> state=STOP, overflow=0.
REQ-036 SHALL cover: full buffer, push+pop same cycle -> count stays 4, oldest entry popped, newest stored.
REQ-037 SHALL cover: reset=0 mid-RUN with count=3 -> next cycle state=IDLE, count=0, empty=1, rd_valid=0.

Source files
------------

// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================
// trace_pkg : shared state encoding and field widths for the trace recorder
// Rev 1.0
// ============================================================
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  localparam int STAMP_W = 16;
  localparam int REG_AW  = 5;

endpackage
`default_nettype wire

// File: rtl/trace_recorder_if.sv
`default_nettype none
// ============================================================
// trace_recorder_if : control, commit-stream and pop-side signals of the recorder
// Rev 1.0
// ============================================================
interface trace_recorder_if
  import trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              start;
  logic              clear;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] inst_in;
  logic              inst_valid;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rd_en;

  logic               rd_valid;
  logic [DATA_W-1:0]  rd_pc;
  logic [DATA_W-1:0]  rd_inst;
  logic [DATA_W-1:0]  rd_wdata;
  logic               rd_we;
  logic [REG_AW-1:0]  rd_waddr;
  logic [STAMP_W-1:0] rd_stamp;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               overflow;
  logic               done;
  logic [1:0]         state;

  modport slave (
    input  start, clear, pc_in, inst_in, inst_valid, rf_we, rf_waddr, rf_wdata, rd_en,
    output rd_valid, rd_pc, rd_inst, rd_wdata, rd_we, rd_waddr, rd_stamp,
    output count, full, empty, overflow, done, state
  );

  modport master (
    output start, clear, pc_in, inst_in, inst_valid, rf_we, rf_waddr, rf_wdata, rd_en,
    input  rd_valid, rd_pc, rd_inst, rd_wdata, rd_we, rd_waddr, rd_stamp,
    input  count, full, empty, overflow, done, state
  );

endinterface
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================
// trace_fifo : circular buffer with registered read port and flush
// Rev 1.0
// ============================================================
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign pop_ok  = pop && !empty && !flush;
  // A full buffer still takes a push when the same cycle frees a slot.
  assign push_ok = push && (!full || pop_ok) && !flush;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok) begin
        rd_ptr_d     = rd_ptr_q + 1'b1;
        dout_d       = mem[rd_ptr_q];
        dout_valid_d = 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign count      = count_q;

endmodule
`default_nettype wire

// File: rtl/trace_recorder.sv
`default_nettype none
// ============================================================
// trace_recorder : run-controlled capture of committed instructions into a trace buffer
// Rev 1.0
// ============================================================
module trace_recorder
  import trace_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int CYCLE_LIMIT = 1200,
  parameter int MODE        = 0,
  parameter int FULL_STOP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  trace_recorder_if.slave  bus
);

  localparam int ENTRY_W = 3*DATA_W + 1 + REG_AW + STAMP_W;
  localparam logic [STAMP_W-1:0] LIMIT_LAST = STAMP_W'(CYCLE_LIMIT - 1);

  state_e             state_q, state_d;
  logic [STAMP_W-1:0] cyc_q, cyc_d;
  logic               overflow_q, overflow_d;
  logic               push;
  logic               eligible;
  logic               fifo_full;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] fifo_dout;

  assign eligible = bus.inst_valid && ((MODE == 0) || bus.rf_we);
  assign entry    = {bus.pc_in, bus.inst_in, bus.rf_we, bus.rf_waddr, bus.rf_wdata, cyc_q};

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    if (bus.clear) begin
      state_d    = ST_IDLE;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d = ST_RUN;
            cyc_d   = '0;
          end
        end
        ST_RUN: begin
          if (!bus.inst_valid) begin
            state_d = ST_STOP;
          end else begin
            if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
            if (eligible) begin
              // Full implies non-empty, so rd_en alone tells whether a slot frees up.
              if (fifo_full && !bus.rd_en) begin
                if (FULL_STOP != 0) state_d = ST_STOP;
                else                overflow_d = 1'b1;
              end else begin
                push = 1'b1;
              end
            end
            if (cyc_q == LIMIT_LAST) state_d = ST_STOP;
          end
        end
        ST_STOP: state_d = ST_STOP;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      overflow_q <= overflow_d;
    end
  end

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (bus.clear),
    .push       (push),
    .pop        (bus.rd_en),
    .din        (entry),
    .dout       (fifo_dout),
    .dout_valid (bus.rd_valid),
    .count      (bus.count),
    .full       (fifo_full),
    .empty      (bus.empty)
  );

  assign {bus.rd_pc, bus.rd_inst, bus.rd_we, bus.rd_waddr, bus.rd_wdata, bus.rd_stamp} = fifo_dout;
  assign bus.full     = fifo_full;
  assign bus.overflow = overflow_q;
  assign bus.done     = (state_q == ST_STOP);
  assign bus.state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_trace_recorder.sv
`default_nettype none
// ============================================================
// tb_trace_recorder : directed self-checking bench over five recorder configurations
// Rev 1.0
// ============================================================
module tb_trace_recorder;
  import trace_pkg::*;

  logic clk = 1'b0;
  logic rst0_n;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  trace_recorder_if #(.DATA_W(32), .DEPTH(64)) bus0 ();
  trace_recorder_if #(.DATA_W(32), .DEPTH(64)) bus1 ();
  trace_recorder_if #(.DATA_W(32), .DEPTH(8))  bus2 ();
  trace_recorder_if #(.DATA_W(32), .DEPTH(4))  bus3 ();
  trace_recorder_if #(.DATA_W(32), .DEPTH(4))  bus4 ();

  trace_recorder #(.DATA_W(32), .DEPTH(64), .CYCLE_LIMIT(1200), .MODE(0), .FULL_STOP(0))
    u_dut0 (.clk(clk), .reset(rst0_n), .bus(bus0));
  trace_recorder #(.DATA_W(32), .DEPTH(64), .CYCLE_LIMIT(1200), .MODE(1), .FULL_STOP(0))
    u_dut1 (.clk(clk), .reset(rst_n), .bus(bus1));
  trace_recorder #(.DATA_W(32), .DEPTH(8), .CYCLE_LIMIT(5), .MODE(0), .FULL_STOP(0))
    u_dut2 (.clk(clk), .reset(rst_n), .bus(bus2));
  trace_recorder #(.DATA_W(32), .DEPTH(4), .CYCLE_LIMIT(1200), .MODE(0), .FULL_STOP(0))
    u_dut3 (.clk(clk), .reset(rst_n), .bus(bus3));
  trace_recorder #(.DATA_W(32), .DEPTH(4), .CYCLE_LIMIT(1200), .MODE(0), .FULL_STOP(1))
    u_dut4 (.clk(clk), .reset(rst_n), .bus(bus4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    bus0.start = 0; bus0.clear = 0; bus0.inst_valid = 0; bus0.rf_we = 0; bus0.rd_en = 0;
    bus0.pc_in = 0; bus0.inst_in = 0; bus0.rf_waddr = 0; bus0.rf_wdata = 0;
    bus1.start = 0; bus1.clear = 0; bus1.inst_valid = 0; bus1.rf_we = 0; bus1.rd_en = 0;
    bus1.pc_in = 0; bus1.inst_in = 0; bus1.rf_waddr = 0; bus1.rf_wdata = 0;
    bus2.start = 0; bus2.clear = 0; bus2.inst_valid = 0; bus2.rf_we = 0; bus2.rd_en = 0;
    bus2.pc_in = 0; bus2.inst_in = 0; bus2.rf_waddr = 0; bus2.rf_wdata = 0;
    bus3.start = 0; bus3.clear = 0; bus3.inst_valid = 0; bus3.rf_we = 0; bus3.rd_en = 0;
    bus3.pc_in = 0; bus3.inst_in = 0; bus3.rf_waddr = 0; bus3.rf_wdata = 0;
    bus4.start = 0; bus4.clear = 0; bus4.inst_valid = 0; bus4.rf_we = 0; bus4.rd_en = 0;
    bus4.pc_in = 0; bus4.inst_in = 0; bus4.rf_waddr = 0; bus4.rf_wdata = 0;
  endtask

  task automatic test_reset();
    n_checks++; if (bus0.state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus0.state); end
    n_checks++; if (bus0.count !== 7'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus0.count); end
    n_checks++; if (bus0.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", bus0.empty); end
    n_checks++; if (bus0.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", bus0.full); end
    n_checks++; if (bus0.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", bus0.rd_valid); end
    n_checks++; if (bus0.done !== 1'b0 || bus0.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got done=%b ovf=%b expected 0 0", bus0.done, bus0.overflow); end
    n_checks++; if (bus0.rd_stamp !== 16'd0 || bus0.rd_pc !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data: got stamp=%0d pc=%h expected 0 0", bus0.rd_stamp, bus0.rd_pc); end
  endtask

  task automatic test_clear_priority();
    bus0.start = 1; bus0.clear = 1;
    tick();
    bus0.start = 0; bus0.clear = 0;
    n_checks++; if (bus0.state !== 2'd0) begin n_fail++; $display("FAIL clear_over_start: got state %0d expected 0", bus0.state); end
  endtask

  task automatic test_mode0();
    bus0.start = 1;
    tick();
    bus0.start = 0;
    n_checks++; if (bus0.state !== 2'd1) begin n_fail++; $display("FAIL m0_run: got state %0d expected 1", bus0.state); end
    for (int i = 0; i < 10; i++) begin
      bus0.inst_valid = 1;
      bus0.pc_in      = 32'h1000 + 32'(4*i);
      bus0.inst_in    = 32'h0000_0013 + 32'(i);
      tick();
    end
    bus0.inst_valid = 0;
    tick();
    n_checks++; if (bus0.state !== 2'd2 || bus0.done !== 1'b1) begin n_fail++; $display("FAIL m0_stop: got state %0d done %b expected 2 1", bus0.state, bus0.done); end
    n_checks++; if (bus0.count !== 7'd10) begin n_fail++; $display("FAIL m0_count: got %0d expected 10", bus0.count); end
    for (int i = 0; i < 10; i++) begin
      bus0.rd_en = 1;
      tick();
      n_checks++;
      if (bus0.rd_valid !== 1'b1 || bus0.rd_stamp !== 16'(i) || bus0.rd_pc !== 32'h1000 + 32'(4*i)
          || bus0.rd_inst !== 32'h13 + 32'(i)) begin
        n_fail++;
        $display("FAIL m0_pop%0d: got v=%b stamp=%0d pc=%h inst=%h expected 1 %0d %h %h", i,
                 bus0.rd_valid, bus0.rd_stamp, bus0.rd_pc, bus0.rd_inst, i, 32'h1000 + 32'(4*i), 32'h13 + 32'(i));
      end
    end
    bus0.rd_en = 0;
    tick();
    n_checks++; if (bus0.rd_valid !== 1'b0 || bus0.empty !== 1'b1) begin n_fail++; $display("FAIL m0_drained: got v=%b empty=%b expected 0 1", bus0.rd_valid, bus0.empty); end
    bus0.clear = 1;
    tick();
    bus0.clear = 0;
    n_checks++; if (bus0.state !== 2'd0 || bus0.done !== 1'b0) begin n_fail++; $display("FAIL m0_clear: got state %0d done %b expected 0 0", bus0.state, bus0.done); end
  endtask

  task automatic test_back_to_back();
    bus0.start = 1;
    tick();
    bus0.start = 0; bus0.inst_valid = 1; bus0.rd_en = 1; bus0.pc_in = 32'h2000;
    tick();
    n_checks++; if (bus0.count !== 7'd1 || bus0.rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got count %0d v=%b expected 1 0", bus0.count, bus0.rd_valid); end
    bus0.pc_in = 32'h2004;
    tick();
    n_checks++; if (bus0.count !== 7'd1 || bus0.rd_valid !== 1'b1 || bus0.rd_stamp !== 16'd0 || bus0.rd_pc !== 32'h2000) begin
      n_fail++; $display("FAIL b2b_stream: got count %0d v=%b stamp=%0d pc=%h expected 1 1 0 2000", bus0.count, bus0.rd_valid, bus0.rd_stamp, bus0.rd_pc);
    end
    bus0.inst_valid = 0; bus0.rd_en = 0;
    tick();
    bus0.clear = 1;
    tick();
    bus0.clear = 0;
  endtask

  task automatic test_reset_mid_run();
    bus0.start = 1;
    tick();
    bus0.start = 0; bus0.inst_valid = 1;
    repeat (3) tick();
    n_checks++; if (bus0.count !== 7'd3) begin n_fail++; $display("FAIL mid_pre_count: got %0d expected 3", bus0.count); end
    bus0.rd_en = 1; rst0_n = 0;
    tick();
    n_checks++; if (bus0.state !== 2'd0 || bus0.count !== 7'd0 || bus0.empty !== 1'b1 || bus0.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got state %0d count %0d empty %b v %b expected 0 0 1 0", bus0.state, bus0.count, bus0.empty, bus0.rd_valid);
    end
    rst0_n = 1; bus0.rd_en = 0; bus0.inst_valid = 0;
    tick();
  endtask

  task automatic test_mode1();
    int exp_c[3] = '{3, 7, 12};
    bus1.start = 1;
    tick();
    bus1.start = 0;
    for (int i = 0; i < 20; i++) begin
      bus1.inst_valid = 1;
      bus1.rf_we      = (i == 3 || i == 7 || i == 12);
      bus1.rf_waddr   = 5'(i + 1);
      bus1.rf_wdata   = 32'hA000 + 32'(i);
      bus1.pc_in      = 32'h400 + 32'(4*i);
      tick();
    end
    bus1.inst_valid = 0; bus1.rf_we = 0;
    tick();
    n_checks++; if (bus1.count !== 7'd3 || bus1.state !== 2'd2) begin n_fail++; $display("FAIL m1_count: got count %0d state %0d expected 3 2", bus1.count, bus1.state); end
    for (int k = 0; k < 3; k++) begin
      bus1.rd_en = 1;
      tick();
      n_checks++;
      if (bus1.rd_stamp !== 16'(exp_c[k]) || bus1.rd_waddr !== 5'(exp_c[k] + 1) || bus1.rd_wdata !== 32'hA000 + 32'(exp_c[k])
          || bus1.rd_we !== 1'b1 || bus1.rd_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL m1_pop%0d: got stamp=%0d waddr=%0d wdata=%h we=%b expected %0d %0d %h 1", k,
                 bus1.rd_stamp, bus1.rd_waddr, bus1.rd_wdata, bus1.rd_we, exp_c[k], exp_c[k] + 1, 32'hA000 + 32'(exp_c[k]));
      end
    end
    bus1.rd_en = 0;
    tick();
  endtask

  task automatic test_cycle_limit();
    bus2.start = 1;
    tick();
    bus2.start = 0; bus2.inst_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 3) begin
        n_checks++; if (bus2.state !== 2'd1) begin n_fail++; $display("FAIL lim_before: got state %0d expected 1", bus2.state); end
      end
    end
    n_checks++; if (bus2.done !== 1'b1 || bus2.count !== 4'd5) begin n_fail++; $display("FAIL lim_stop: got done %b count %0d expected 1 5", bus2.done, bus2.count); end
    repeat (2) tick();
    n_checks++; if (bus2.count !== 4'd5) begin n_fail++; $display("FAIL lim_hold: got count %0d expected 5", bus2.count); end
    bus2.inst_valid = 0;
  endtask

  task automatic test_overflow();
    bus3.start = 1; bus4.start = 1;
    tick();
    bus3.start = 0; bus4.start = 0; bus3.inst_valid = 1; bus4.inst_valid = 1;
    repeat (6) tick();
    n_checks++; if (bus3.count !== 3'd4 || bus3.overflow !== 1'b1 || bus3.state !== 2'd1 || bus3.full !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drop: got count %0d ovf %b state %0d full %b expected 4 1 1 1", bus3.count, bus3.overflow, bus3.state, bus3.full);
    end
    n_checks++; if (bus4.count !== 3'd4 || bus4.overflow !== 1'b0 || bus4.state !== 2'd2) begin
      n_fail++; $display("FAIL ovf_fullstop: got count %0d ovf %b state %0d expected 4 0 2", bus4.count, bus4.overflow, bus4.state);
    end
    bus3.inst_valid = 0; bus4.inst_valid = 0; bus3.clear = 1; bus4.clear = 1;
    tick();
    bus3.clear = 0; bus4.clear = 0;
    n_checks++; if (bus3.overflow !== 1'b0 || bus3.empty !== 1'b1) begin n_fail++; $display("FAIL ovf_clear: got ovf %b empty %b expected 0 1", bus3.overflow, bus3.empty); end
  endtask

  task automatic test_full_push_pop();
    bus3.start = 1;
    tick();
    bus3.start = 0;
    for (int i = 0; i < 4; i++) begin
      bus3.inst_valid = 1;
      bus3.pc_in      = 32'h3000 + 32'(i);
      tick();
    end
    n_checks++; if (bus3.full !== 1'b1) begin n_fail++; $display("FAIL fpp_full: got %b expected 1", bus3.full); end
    bus3.rd_en = 1; bus3.pc_in = 32'h3FFF;
    tick();
    n_checks++; if (bus3.count !== 3'd4 || bus3.overflow !== 1'b0 || bus3.rd_valid !== 1'b1 || bus3.rd_stamp !== 16'd0 || bus3.rd_pc !== 32'h3000) begin
      n_fail++; $display("FAIL fpp_both: got count %0d ovf %b v %b stamp %0d pc %h expected 4 0 1 0 3000",
                         bus3.count, bus3.overflow, bus3.rd_valid, bus3.rd_stamp, bus3.rd_pc);
    end
    bus3.inst_valid = 0; bus3.rd_en = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus3.rd_en = 1;
      tick();
      n_checks++;
      if (bus3.rd_stamp !== 16'(i + 1) || bus3.rd_pc !== ((i == 3) ? 32'h3FFF : 32'h3001 + 32'(i))) begin
        n_fail++; $display("FAIL fpp_pop%0d: got stamp %0d pc %h expected %0d %h", i, bus3.rd_stamp, bus3.rd_pc,
                           i + 1, (i == 3) ? 32'h3FFF : 32'h3001 + 32'(i));
      end
    end
    bus3.rd_en = 0;
    tick();
  endtask

  initial begin
    rst0_n = 0;
    rst_n  = 0;
    init_inputs();
    repeat (2) tick();
    test_reset();
    rst0_n = 1;
    rst_n  = 1;
    tick();
    test_clear_priority();
    test_mode0();
    test_back_to_back();
    test_reset_mid_run();
    test_mode1();
    test_cycle_limit();
    test_overflow();
    test_full_push_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
